// File: rtl/gal_olmc_cfg_loader_pkg.sv
// gal_cfg_pkg: shared definitions for the GAL OLMC configuration loader.
//   SYNC          - frame sync byte that opens every configuration image
//   gal_state_e   - loader FSM states
//   nbytes()      - number of stream bytes needed to carry a cfg_w-bit image
//   REG_BIT/INV_BIT - positions of the mode bits inside one OLMC field
package gal_cfg_pkg;

    localparam logic [7:0] SYNC = 8'hA5;

    // Mode-bit positions within CFG[i*BITS_PER_OLMC +: BITS_PER_OLMC].
    localparam int REG_BIT = 0;
    localparam int INV_BIT = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        LOAD   = 3'd2,
        CHK    = 3'd3,
        COMMIT = 3'd4,
        ERROR  = 3'd5
    } gal_state_e;

    function automatic int nbytes(input int cfg_w);
        return (cfg_w + 7) / 8;
    endfunction

endpackage

// File: rtl/gal_olmc_cfg_loader_if.sv
// gal_cfg_stream_if: byte stream from the host into the configuration loader.
//   S_DATA  - stream byte
//   S_VALID - S_DATA valid
//   S_READY - loader accepts a byte this cycle
// Handshake: a byte transfers on a rising clock edge where S_VALID && S_READY
// are both high; S_DATA is don't-care otherwise. The host may hold or drop
// S_VALID freely; S_READY is a registered function of loader state only.
interface gal_cfg_stream_if;
    logic [7:0] S_DATA;
    logic       S_VALID;
    logic       S_READY;

    modport master (output S_DATA, output S_VALID, input S_READY);
    modport slave  (input S_DATA, input S_VALID, output S_READY);
endinterface

// File: rtl/gal_olmc_cfg_loader_shadow.sv
// gal_cfg_shadow: byte-addressed shadow register plus running XOR checksum.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - zero shadow and accumulator (priority over wr_en)
//   wr_en      - write wr_byte into byte lane wr_idx and fold it into acc
//   wr_idx     - byte lane, LSB-first
//   wr_byte    - data byte
//   shadow     - assembled image (bits above W in the top lane are dropped)
//   acc        - XOR of every byte written since the last clear
module gal_cfg_shadow
    import gal_cfg_pkg::*;
#(
    parameter  int W  = 16,
    localparam int NB = nbytes(W),
    localparam int CW = $clog2(NB + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_idx,
    input  logic [7:0]    wr_byte,
    output logic [W-1:0]  shadow,
    output logic [7:0]    acc
);

    logic [W-1:0]    shadow_q, shadow_d;
    logic [7:0]      acc_q, acc_d;
    logic [NB*8-1:0] wide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            acc_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        wide          = '0;
        wide[W-1:0]   = shadow_q;
        acc_d         = acc_q;
        if (clr) begin
            wide  = '0;
            acc_d = '0;
        end else if (wr_en) begin
            // The full byte always enters the checksum, even where its
            // upper bits have no home in the shadow.
            acc_d = acc_q ^ wr_byte;
            for (int k = 0; k < NB; k++) begin
                if (wr_idx == CW'(k)) wide[k*8 +: 8] = wr_byte;
            end
        end
        shadow_d = wide[W-1:0];
    end

    assign shadow = shadow_q;
    assign acc    = acc_q;

endmodule

// File: rtl/gal_olmc_cfg_loader.sv
// gal_olmc_cfg_loader: framed byte-stream loader for the GAL OLMC mode bits.
// Frame = SYNC, NBYTES payload bytes (LSB-first), XOR checksum of payload.
// The image is built in a shadow register and copied to CFG in one step only
// when the checksum matches, so the OLMC array never sees a partial image.
//   C, R_N    - clock, asynchronous active-low reset
//   START     - begin a load (IDLE only); clears ERR
//   ABORT     - back to IDLE without touching CFG/ERR (ignored in COMMIT)
//   s         - byte stream (slave side)
//   CFG       - committed configuration, OLMC i at [i*BITS_PER_OLMC +: BITS_PER_OLMC]
//   BUSY      - not IDLE
//   DONE      - one-cycle pulse, coincident with the new CFG
//   ERR       - sticky sync/checksum error flag
//   STATE_DBG - current FSM state
module gal_olmc_cfg_loader
    import gal_cfg_pkg::*;
#(
    parameter  int                 N_OLMC        = 8,
    parameter  int                 BITS_PER_OLMC = 2,
    localparam int                 CFG_W         = N_OLMC * BITS_PER_OLMC,
    parameter  logic [CFG_W-1:0]   CFG_RESET     = '0,
    localparam int                 NB            = nbytes(CFG_W),
    localparam int                 CW            = $clog2(NB + 1)
) (
    input  logic             C,
    input  logic             R_N,
    input  logic             START,
    input  logic             ABORT,
    gal_cfg_stream_if.slave  s,
    output logic [CFG_W-1:0] CFG,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output gal_state_e       STATE_DBG
);

    gal_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             err_q, err_d;
    logic             s_ready_q, s_ready_d;

    logic             sh_clr, sh_wr, take;
    logic [CFG_W-1:0] sh_image;
    logic [7:0]       sh_acc;

    gal_cfg_shadow #(.W(CFG_W)) u_shadow (
        .clk     (C),
        .rst_n   (R_N),
        .clr     (sh_clr),
        .wr_en   (sh_wr),
        .wr_idx  (cnt_q),
        .wr_byte (s.S_DATA),
        .shadow  (sh_image),
        .acc     (sh_acc)
    );

    // State register
    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cfg_q     <= CFG_RESET;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
        end
    end

    // Next state. ABORT outranks consumption, so a byte offered alongside
    // ABORT is never taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        sh_clr  = 1'b0;
        sh_wr   = 1'b0;
        take    = s.S_VALID && s_ready_q && !ABORT;
        unique case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    state_d = HDR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    sh_clr  = 1'b1;
                end
            end
            HDR: begin
                if (ABORT)     state_d = IDLE;
                else if (take) state_d = (s.S_DATA == SYNC) ? LOAD : ERROR;
            end
            LOAD: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (take) begin
                    sh_wr = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(NB - 1)) state_d = CHK;
                end
            end
            CHK: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (take) begin
                    // CFG is loaded on the same edge that enters COMMIT so
                    // DONE (decoded from COMMIT) lines up with the new CFG.
                    if (s.S_DATA == sh_acc) begin
                        state_d = COMMIT;
                        cfg_d   = sh_image;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            COMMIT: state_d = IDLE;
            ERROR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == HDR) || (state_d == LOAD) || (state_d == CHK);
    end

    // Outputs
    always_comb begin
        s.S_READY = s_ready_q;
        CFG       = cfg_q;
        ERR       = err_q;
        BUSY      = (state_q != IDLE);
        DONE      = (state_q == COMMIT);
        STATE_DBG = state_q;
    end

endmodule

// File: tb/tb_gal_olmc_cfg_loader.sv
module tb_gal_olmc_cfg_loader;
    import gal_cfg_pkg::*;

    logic        C;
    logic        R_N;
    logic        START;
    logic        ABORT;
    logic [15:0] CFG;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    gal_state_e  STATE_DBG;

    gal_cfg_stream_if sif ();

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    gal_olmc_cfg_loader #(
        .N_OLMC        (8),
        .BITS_PER_OLMC (2),
        .CFG_RESET     (16'h0000)
    ) dut (
        .C         (C),
        .R_N       (R_N),
        .START     (START),
        .ABORT     (ABORT),
        .s         (sif),
        .CFG       (CFG),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .STATE_DBG (STATE_DBG)
    );

    // Clock and watchdog
    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Count DONE cycles, sampled mid-cycle
    always @(negedge C) if (DONE === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drivers: called at a negedge, return at a negedge.
    task automatic pulse_start();
        START = 1'b1;
        @(negedge C);
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        sif.S_DATA  = b;
        sif.S_VALID = 1'b1;
        while (sif.S_READY !== 1'b1 && n < 20) begin
            @(negedge C);
            n++;
        end
        if (sif.S_READY !== 1'b1) check("ready_wait", 32'(sif.S_READY), 32'd1);
        else @(posedge C);
        @(negedge C);
        sif.S_VALID = 1'b0;
        sif.S_DATA  = 8'h00;
    endtask

    task automatic send_stalled(input logic [7:0] b);
        send_byte(b);
        repeat (2) @(negedge C);
    endtask

    int d0;

    initial begin
        R_N         = 1'b0;
        START       = 1'b0;
        ABORT       = 1'b0;
        sif.S_DATA  = 8'h00;
        sif.S_VALID = 1'b0;
        repeat (2) @(negedge C);

        // Reset values
        check("rst_cfg",   32'(CFG), 32'h0000);
        check("rst_busy",  32'(BUSY), 32'd0);
        check("rst_done",  32'(DONE), 32'd0);
        check("rst_err",   32'(ERR), 32'd0);
        check("rst_ready", 32'(sif.S_READY), 32'd0);
        check("rst_state", 32'(STATE_DBG), 32'(IDLE));
        R_N = 1'b1;
        @(negedge C);

        // Bad checksum: A5,34,12,00 (correct would be 26)
        pulse_start();
        check("start_busy",  32'(BUSY), 32'd1);
        check("start_ready", 32'(sif.S_READY), 32'd1);
        send_byte(8'hA5);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h00);
        @(negedge C);
        check("badck_state", 32'(STATE_DBG), 32'(IDLE));
        check("badck_err",   32'(ERR), 32'd1);
        check("badck_cfg",   32'(CFG), 32'h0000);
        check("badck_done",  32'(done_cnt), 32'd0);

        // Bad sync byte
        pulse_start();
        check("start_clr_err", 32'(ERR), 32'd0);
        send_byte(8'h5A);
        check("badsync_ready", 32'(sif.S_READY), 32'd0);
        @(negedge C);
        check("badsync_err",   32'(ERR), 32'd1);
        check("badsync_busy",  32'(BUSY), 32'd0);

        // Recovery load A5,FF,00,FF -> 00FF
        pulse_start();
        check("restart_err", 32'(ERR), 32'd0);
        send_byte(8'hA5);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'hFF);
        check("rec_done", 32'(DONE), 32'd1);
        check("rec_cfg",  32'(CFG), 32'h00FF);
        @(negedge C);
        check("rec_busy", 32'(BUSY), 32'd0);

        // Good load A5,34,12,26 -> 1234, DONE exactly one cycle
        d0 = done_cnt;
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h34);
        send_byte(8'h12);
        check("good_cfg_hold", 32'(CFG), 32'h00FF);
        send_byte(8'h26);
        check("good_done", 32'(DONE), 32'd1);
        check("good_cfg",  32'(CFG), 32'h1234);
        check("good_busy_commit", 32'(BUSY), 32'd1);
        @(negedge C);
        check("good_done_low", 32'(DONE), 32'd0);
        check("good_busy_low", 32'(BUSY), 32'd0);
        check("good_err",      32'(ERR), 32'd0);
        check("good_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Stalled stream A5,CD,AB,66 -> ABCD
        pulse_start();
        send_stalled(8'hA5);
        send_stalled(8'hCD);
        check("stall_state", 32'(STATE_DBG), 32'(LOAD));
        send_stalled(8'hAB);
        check("stall_state_chk", 32'(STATE_DBG), 32'(CHK));
        send_byte(8'h66);
        check("stall_cfg",  32'(CFG), 32'hABCD);
        check("stall_done", 32'(DONE), 32'd1);
        @(negedge C);

        // ABORT after byte 34; byte 12 offered with ABORT is not taken
        d0 = done_cnt;
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h34);
        sif.S_DATA  = 8'h12;
        sif.S_VALID = 1'b1;
        ABORT       = 1'b1;
        @(negedge C);
        ABORT       = 1'b0;
        sif.S_VALID = 1'b0;
        check("abort_state", 32'(STATE_DBG), 32'(IDLE));
        check("abort_ready", 32'(sif.S_READY), 32'd0);
        check("abort_cfg",   32'(CFG), 32'hABCD);
        check("abort_err",   32'(ERR), 32'd0);
        repeat (2) @(negedge C);
        check("abort_done",  32'(done_cnt - d0), 32'd0);

        // START mid-load is ignored: A5,78,(START),56,2E -> 5678
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h78);
        pulse_start();
        check("midstart_state", 32'(STATE_DBG), 32'(LOAD));
        send_byte(8'h56);
        send_byte(8'h2E);
        check("midstart_cfg", 32'(CFG), 32'h5678);
        @(negedge C);

        // Asynchronous reset mid-load
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h11);
        #2;
        R_N = 1'b0;
        #1;
        check("amid_cfg",   32'(CFG), 32'h0000);
        check("amid_busy",  32'(BUSY), 32'd0);
        check("amid_ready", 32'(sif.S_READY), 32'd0);
        check("amid_state", 32'(STATE_DBG), 32'(IDLE));
        @(negedge C);
        R_N = 1'b1;
        @(negedge C);

        // Full load after reset: A5,EF,BE,51 -> BEEF
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'h51);
        check("post_rst_cfg",  32'(CFG), 32'hBEEF);
        check("post_rst_done", 32'(DONE), 32'd1);
        @(negedge C);
        check("post_rst_err",  32'(ERR), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
